// File: rtl/psram_stream_controller.sv
// psram_stream_controller
//   Record/playback controller for an asynchronous PSRAM (16-bit bus, 23-bit
//   address). Recording writes handshaked samples to consecutive addresses
//   starting at 0. Playback reads the recorded region back through a one-entry
//   output register.
//
//   Optional feature macro: PSRAM_LOOP_PLAYBACK_EN. When it is defined,
//   playback wraps to address 0 after the last recorded word and PlayDone
//   stays low.
//
// Ports
//   Clock, Reset                system clock; asynchronous active-low reset
//   RecordEn, PlayEn            mode levels; a rising edge (re)starts the mode
//   WrValid/WrReady/WrData      record stream in (DATA_W bits)
//   RdValid/RdReady/RdData      playback stream out (OUT_W-bit MSB slice)
//   MemAdr, MemDB               PSRAM address and bidirectional data bus
//   RamCEn/RamOEn/RamWEn        PSRAM strobes (active low)
//   RamADVn/UBn/LBn/CRE         tied low
//   Full, PlayDone, RecLen      status outputs
module psram_stream_controller #(
  parameter int DATA_W     = 12,
  parameter int OUT_W      = 8,
  parameter int DEPTH      = 1024,
  parameter int ACCESS_CYC = 10,
  parameter int WE_START   = 5,
  parameter int OE_START   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RecordEn,
  input  logic              PlayEn,
  input  logic              WrValid,
  output logic              WrReady,
  input  logic [DATA_W-1:0] WrData,
  output logic              RdValid,
  input  logic              RdReady,
  output logic [OUT_W-1:0]  RdData,
  output logic [22:0]       MemAdr,
  inout  wire  [15:0]       MemDB,
  output logic              RamCEn,
  output logic              RamOEn,
  output logic              RamWEn,
  output logic              RamADVn,
  output logic              RamUBn,
  output logic              RamLBn,
  output logic              RamCRE,
  output logic              Full,
  output logic              PlayDone,
  output logic [22:0]       RecLen
);

  typedef enum logic [1:0] {IDLE, WR_ACC, RD_ACC, RECOV} state_t;

  state_t            state, nxtState;
  logic [3:0]        cnt, nxtCnt;
  // One extra pointer bit so that a pointer equal to DEPTH = 2^23 still fits.
  logic [23:0]       wrPtr, rdPtr, recLen, rdNext;
  logic [DATA_W-1:0] wrBuf;
  logic              recPrev, playPrev, recPend, rdDiscard, dbOe;
  logic              recRise, playRise, accLast, wrFire, rdLaunch;
  logic              unusedBus;

  assign RamADVn = 1'b0;
  assign RamUBn  = 1'b0;
  assign RamLBn  = 1'b0;
  assign RamCRE  = 1'b0;

  assign recRise  = RecordEn & ~recPrev;
  assign playRise = PlayEn & ~playPrev;
  assign accLast  = (state == WR_ACC || state == RD_ACC) && cnt == 4'(ACCESS_CYC);
  assign Full     = (wrPtr == 24'(DEPTH));
  assign RecLen   = recLen[22:0];

  // The pointer clear for a new recording has to land before the first sample
  // is accepted. For that reason WrReady is held low while a clear is pending.
  assign WrReady  = (state == IDLE) & RecordEn & ~Full & ~recRise & ~recPend;
  assign wrFire   = WrValid & WrReady;

  // The PlayEn rising cycle is skipped because RdPtr is being rewound on that
  // same edge.
  assign rdLaunch = (state == IDLE) & PlayEn & ~playRise & ~RecordEn &
                    (rdPtr < recLen) & (~RdValid | RdReady);

`ifdef PSRAM_LOOP_PLAYBACK_EN
  assign rdNext   = (rdPtr + 24'd1 >= recLen) ? '0 : rdPtr + 24'd1;
  assign PlayDone = 1'b0;
`else
  assign rdNext   = rdPtr + 24'd1;
  assign PlayDone = PlayEn & ~playRise & (rdPtr == recLen) & ~RdValid;
`endif

  assign MemDB     = dbOe ? 16'(wrBuf) : 16'hzzzz;
  assign unusedBus = ^MemDB;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxtState;
      cnt   <= nxtCnt;
    end
  end

  always_comb begin
    nxtState = state;
    nxtCnt   = cnt;
    case (state)
      IDLE: begin
        if (wrFire) begin
          nxtState = WR_ACC;
          nxtCnt   = 4'd1;
        end else if (rdLaunch) begin
          nxtState = RD_ACC;
          nxtCnt   = 4'd1;
        end
      end
      WR_ACC, RD_ACC: begin
        if (cnt == 4'(ACCESS_CYC)) begin
          nxtState = RECOV;
          nxtCnt   = '0;
        end else begin
          nxtCnt = cnt + 4'd1;
        end
      end
      RECOV:   nxtState = IDLE;
      default: nxtState = IDLE;
    endcase
  end

  // The strobes and the bus enable are registered from the next state, so the
  // pins are glitch-free and line up exactly with the access counter. The
  // asynchronous reset forces them high the moment Reset falls, which aborts
  // any access in progress.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      RamCEn    <= 1'b1;
      RamOEn    <= 1'b1;
      RamWEn    <= 1'b1;
      dbOe      <= 1'b0;
      MemAdr    <= '0;
      wrBuf     <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      recLen    <= '0;
      recPrev   <= 1'b0;
      playPrev  <= 1'b0;
      recPend   <= 1'b0;
      rdDiscard <= 1'b0;
      RdValid   <= 1'b0;
      RdData    <= '0;
    end else begin
      recPrev  <= RecordEn;
      playPrev <= PlayEn;
      RamCEn   <= ~(nxtState == WR_ACC || nxtState == RD_ACC);
      RamWEn   <= ~(nxtState == WR_ACC && nxtCnt >= 4'(WE_START));
      RamOEn   <= ~(nxtState == RD_ACC && nxtCnt >= 4'(OE_START));
      dbOe     <= (nxtState == WR_ACC);

      if (wrFire) begin
        wrBuf  <= WrData;
        MemAdr <= wrPtr[22:0];
      end else if (rdLaunch) begin
        MemAdr <= rdPtr[22:0];
      end

      // A new recording takes effect only once the bus is idle.
      if (state == IDLE && (recRise || recPend)) begin
        wrPtr   <= '0;
        recLen  <= '0;
        recPend <= 1'b0;
      end else if (recRise) begin
        recPend <= 1'b1;
      end
      if (state == WR_ACC && accLast) begin
        wrPtr  <= wrPtr + 24'd1;
        recLen <= wrPtr + 24'd1;
      end

      if (RdValid && RdReady) RdValid <= 1'b0;
      // A read that is overtaken by a mode restart still runs to completion
      // on the bus. Its data is dropped, and RdPtr does not advance.
      if (state == RD_ACC && (recRise || playRise)) rdDiscard <= 1'b1;
      if (state == RD_ACC && accLast) begin
        if (!(rdDiscard || recRise || playRise)) begin
          RdData  <= MemDB[DATA_W-1 -: OUT_W];
          RdValid <= 1'b1;
          rdPtr   <= rdNext;
        end
        rdDiscard <= 1'b0;
      end
      if (playRise) begin
        rdPtr   <= '0;
        RdValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psram_stream_controller.sv
// Directed bench for psram_stream_controller (DEPTH=4, other parameters at
// their defaults). It includes a behavioural PSRAM model and an access
// monitor that logs the address, data and strobe pattern of every access.
module tb_psram_stream_controller;
  localparam int DATA_W = 12;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 4;
  localparam int AC     = 10;

  logic              Clock = 1'b0, Reset = 1'b0;
  logic              RecordEn = 1'b0, PlayEn = 1'b0, WrValid = 1'b0, RdReady = 1'b0;
  logic [DATA_W-1:0] WrData = '0;
  logic              WrReady, RdValid, Full, PlayDone;
  logic [OUT_W-1:0]  RdData;
  logic [22:0]       MemAdr, RecLen;
  wire  [15:0]       MemDB;
  logic              RamCEn, RamOEn, RamWEn, RamADVn, RamUBn, RamLBn, RamCRE;

  psram_stream_controller #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
    .ACCESS_CYC(AC), .WE_START(5), .OE_START(8)) dut (
    .Clock(Clock), .Reset(Reset), .RecordEn(RecordEn), .PlayEn(PlayEn),
    .WrValid(WrValid), .WrReady(WrReady), .WrData(WrData),
    .RdValid(RdValid), .RdReady(RdReady), .RdData(RdData),
    .MemAdr(MemAdr), .MemDB(MemDB), .RamCEn(RamCEn), .RamOEn(RamOEn),
    .RamWEn(RamWEn), .RamADVn(RamADVn), .RamUBn(RamUBn), .RamLBn(RamLBn),
    .RamCRE(RamCRE), .Full(Full), .PlayDone(PlayDone), .RecLen(RecLen));

  always #5 Clock = ~Clock;

  // PSRAM model
  logic [15:0] mem [0:15];
  assign MemDB = (!RamCEn && !RamOEn && RamWEn) ? mem[MemAdr[3:0]] : 16'hzzzz;

  typedef struct {
    logic [22:0] adr;
    logic [15:0] dat;
    logic [15:0] weM;
    logic [15:0] oeM;
    int          len;
  } acc_t;
  acc_t accLog[$];
  acc_t cur;
  int   accC = 0;

  always @(negedge Clock) begin
    if (!RamCEn) begin
      accC++;
      if (accC == 1) begin
        cur.adr = MemAdr; cur.dat = '0; cur.weM = '0; cur.oeM = '0;
      end
      if (!RamWEn) begin
        cur.weM[accC] = 1'b1;
        cur.dat = MemDB;
        mem[MemAdr[3:0]] = MemDB;
      end
      if (!RamOEn) cur.oeM[accC] = 1'b1;
    end else if (accC != 0) begin
      cur.len = accC;
      accLog.push_back(cur);
      accC = 0;
    end
  end

  int nTests = 0, nFail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic sendSample(input logic [DATA_W-1:0] d, output bit ok);
    WrData = d; WrValid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clock);
      if (WrReady) begin
        @(posedge Clock); #1;
        ok = 1'b1;
      end
    end
    WrValid = 1'b0;
  endtask

  task automatic getSample(output logic [OUT_W-1:0] d, output int lat, output bit ok);
    ok = 1'b0; lat = 0; d = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge Clock);
      lat++;
      if (RdValid) begin
        d = RdData;
        ok = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit             ok;
    int             lat, nAcc, bad;
    logic [OUT_W-1:0] d;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    tick(3);
    @(negedge Clock);
    chk("rst_cen", 32'(RamCEn), 1);
    chk("rst_wen", 32'(RamWEn), 1);
    chk("rst_oen", 32'(RamOEn), 1);
    chk("rst_db_z", 32'(MemDB === 16'hzzzz), 1);
    chk("rst_wrready", 32'(WrReady), 0);
    chk("rst_rdvalid", 32'(RdValid), 0);
    chk("rst_rddata", 32'(RdData), 0);
    chk("rst_full", 32'(Full), 0);
    chk("rst_playdone", 32'(PlayDone), 0);
    chk("rst_reclen", 32'(RecLen), 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    tick(2);

    // Record two samples
    RecordEn = 1'b1;
    sendSample(12'h123, ok); chk("rec1_acc", 32'(ok), 1);
    sendSample(12'hABC, ok); chk("rec2_acc", 32'(ok), 1);
    tick(15);
    chk("rec_nacc", 32'(accLog.size()), 2);
    if (accLog.size() >= 2) begin
      chk("rec_adr0", 32'(accLog[0].adr), 0);
      chk("rec_dat0", 32'(accLog[0].dat), 32'h0123);
      chk("rec_we0", 32'(accLog[0].weM), 32'h07E0);
      chk("rec_len0", 32'(accLog[0].len), AC);
      chk("rec_oe0", 32'(accLog[0].oeM), 0);
      chk("rec_adr1", 32'(accLog[1].adr), 1);
      chk("rec_dat1", 32'(accLog[1].dat), 32'h0ABC);
      chk("rec_we1", 32'(accLog[1].weM), 32'h07E0);
    end
    chk("rec_reclen", 32'(RecLen), 2);
    chk("rec_full", 32'(Full), 0);
    RecordEn = 1'b0;
    tick(2);

    // Playback with RdReady held high
    accLog.delete();
    RdReady = 1'b1;
    PlayEn  = 1'b1;
    getSample(d, lat, ok);
    chk("play1_ok", 32'(ok), 1);
    chk("play1_dat", 32'(d), 32'h12);
    // One cycle for edge detection and one launch cycle, then AC+1 to RdValid.
    chk("play1_lat", 32'(lat), 2 + AC + 1);
    chk("play1_done", 32'(PlayDone), 0);
    @(posedge Clock); #1;
    getSample(d, lat, ok);
    chk("play2_ok", 32'(ok), 1);
    chk("play2_dat", 32'(d), 32'hAB);
`ifndef PSRAM_LOOP_PLAYBACK_EN
    @(negedge Clock);
    chk("play_done", 32'(PlayDone), 1);
    @(posedge Clock); #1;
    PlayEn = 1'b0;
    @(negedge Clock);
    chk("play_done_clr", 32'(PlayDone), 0);
`else
    @(posedge Clock); #1;
    PlayEn = 1'b0;
`endif
    tick(15);
    chk("play_nacc", 32'(accLog.size()), 2);
    if (accLog.size() >= 2) begin
      chk("play_adr0", 32'(accLog[0].adr), 0);
      chk("play_oe0", 32'(accLog[0].oeM), 32'h0700);
      chk("play_we0", 32'(accLog[0].weM), 0);
      chk("play_adr1", 32'(accLog[1].adr), 1);
    end

    // Back-pressure: RdReady low for 30 cycles
    accLog.delete();
    RdReady = 1'b0;
    PlayEn  = 1'b1;
    getSample(d, lat, ok);
    chk("stall_first", 32'(d), 32'h12);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (!RdValid || RdData !== 8'h12) bad++;
    end
    chk("stall_hold", 32'(bad), 0);
    chk("stall_reads", 32'(accLog.size()), 1);
    @(posedge Clock); #1;
    RdReady = 1'b1;
    @(posedge Clock); #1;
    getSample(d, lat, ok);
    chk("stall_second", 32'(d), 32'hAB);
    tick(2);
    PlayEn = 1'b0;
    tick(15);

    // Full: DEPTH=4, offer six samples
    accLog.delete();
    RecordEn = 1'b1;
    nAcc = 0;
    for (int i = 0; i < 6; i++) begin
      sendSample(12'(12'h101 + i), ok);
      if (ok) nAcc++;
    end
    tick(2);
    chk("full_accepted", 32'(nAcc), 4);
    chk("full_nacc", 32'(accLog.size()), 4);
    for (int i = 0; i < 4 && i < accLog.size(); i++)
      chk($sformatf("full_adr%0d", i), 32'(accLog[i].adr), 32'(i));
    @(negedge Clock);
    chk("full_flag", 32'(Full), 1);
    chk("full_wrready", 32'(WrReady), 0);
    chk("full_reclen", 32'(RecLen), 4);
    @(posedge Clock); #1;
    RecordEn = 1'b0;
    tick(3);

    // Reset during c=6 of a write
    RecordEn = 1'b1;
    sendSample(12'h055, ok);
    chk("rstw_acc", 32'(ok), 1);
    repeat (5) @(posedge Clock);
    #2;
    chk("rstw_mid_ce", 32'(RamCEn), 0);
    chk("rstw_mid_we", 32'(RamWEn), 0);
    Reset = 1'b0;
    #1;
    chk("rstw_ce", 32'(RamCEn), 1);
    chk("rstw_we", 32'(RamWEn), 1);
    chk("rstw_db_z", 32'(MemDB === 16'hzzzz), 1);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("rstw_reclen", 32'(RecLen), 0);
    chk("rstw_full", 32'(Full), 0);
    bad = 1;
    for (int i = 0; i < 5 && bad != 0; i++) begin
      @(negedge Clock);
      if (WrReady) bad = 0;
    end
    chk("rstw_idle", 32'(bad), 0);
    tick(1);

`ifdef PSRAM_LOOP_PLAYBACK_EN
    // Loop playback over three recorded words
    sendSample(12'h311, ok);
    sendSample(12'h322, ok);
    sendSample(12'h333, ok);
    tick(15);
    RecordEn = 1'b0;
    tick(2);
    accLog.delete();
    RdReady = 1'b1;
    PlayEn  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      getSample(d, lat, ok);
      chk($sformatf("loop_dat%0d", i), 32'(d), 32'h31 + 32'(i % 3));
      chk($sformatf("loop_done%0d", i), 32'(PlayDone), 0);
      @(posedge Clock); #1;
    end
    PlayEn = 1'b0;
    tick(15);
    for (int i = 0; i < 6 && i < accLog.size(); i++)
      chk($sformatf("loop_adr%0d", i), 32'(accLog[i].adr), 32'(i % 3));
`endif

    RecordEn = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
